alu_multiciclo: RTL

- Parametrised, multi-cycle successor to the datapath ALU.
- Adds a start/busy/done handshake, registered results, signed/unsigned compares, shifts, and iterative unsigned multiply/divide with a HI result register.
- Sits in the EX stage of the multi-cycle CPU. The controller asserts start and waits for done before writeback.

---
 rtl/alu_multiciclo.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle ALU ops plus iterative unsigned MULU/DIVU behind a start/done handshake.
// Optional signed-overflow flag port Ovf is built only when ALU_OVF_EN is defined.
module alu_multiciclo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic [3:0]       ALU_Control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Salida,
  output logic [WIDTH-1:0] Hi,
  output logic             ZF,
  output logic             DivZero
`ifdef ALU_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpSra  = 4'b1001;
  localparam logic [3:0] OpMulu = 4'b1010;
  localparam logic [3:0] OpDivu = 4'b1011;
  localparam logic [3:0] OpNor  = 4'b1100;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] wh_q, wh_d;     // product HI / partial remainder
  logic [WIDTH-1:0] wl_q, wl_d;     // multiplier->product LO / dividend->quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand or divisor
  logic [WIDTH-1:0] salida_q, salida_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zf_q, zf_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum, div_r, div_sub;

  assign sum   = OP1 + OP2;
  assign diff  = OP1 - OP2;
  assign shamt = OP2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALU_Control)
      OpAdd:   alu_res = sum;
      OpSub:   alu_res = diff;
      OpAnd:   alu_res = OP1 & OP2;
      OpOr:    alu_res = OP1 | OP2;
      OpXor:   alu_res = OP1 ^ OP2;
      OpNor:   alu_res = ~(OP1 | OP2);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(OP1) < $signed(OP2)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, OP1 < OP2};
      OpSll:   alu_res = OP1 << shamt;
      OpSrl:   alu_res = OP1 >> shamt;
      OpSra:   alu_res = $signed(OP1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand if LSB set, then shift {carry, HI, LO} right.
  assign mul_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opb_q} : '0);
  // One restoring step: bit WIDTH of div_sub set means the trial subtraction borrowed.
  assign div_r   = {wh_q, wl_q[WIDTH-1]};
  assign div_sub = div_r - {1'b0, opb_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    opb_d    = opb_q;
    salida_d = salida_q;
    hi_d     = hi_q;
    zf_d     = zf_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (ALU_Control == OpMulu) begin
            wh_d    = '0;
            wl_d    = OP2;
            opb_d   = OP1;
            state_d = StMul;
          end else if (ALU_Control == OpDivu && OP2 != '0) begin
            wh_d    = '0;
            wl_d    = OP1;
            opb_d   = OP2;
            state_d = StDiv;
          end else if (ALU_Control == OpDivu) begin
            salida_d = '1;
            hi_d     = OP1;
            zf_d     = 1'b0;
            dz_d     = 1'b1;
            done_d   = 1'b1;
          end else begin
            salida_d = alu_res;
            zf_d     = (alu_res == '0);
            dz_d     = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        wh_d  = mul_sum[WIDTH:1];
        wl_d  = {mul_sum[0], wl_q[WIDTH-1:1]};
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == '1) state_d = StFin;
      end
      StDiv: begin
        if (!div_sub[WIDTH]) begin
          wh_d = div_sub[WIDTH-1:0];
          wl_d = {wl_q[WIDTH-2:0], 1'b1};
        end else begin
          wh_d = div_r[WIDTH-1:0];
          wl_d = {wl_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == '1) state_d = StFin;
      end
      StFin: begin
        salida_d = wl_q;
        hi_d     = wh_q;
        zf_d     = (wl_q == '0);
        dz_d     = 1'b0;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wh_q     <= '0;
      wl_q     <= '0;
      opb_q    <= '0;
      salida_q <= '0;
      hi_q     <= '0;
      zf_q     <= 1'b1;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      opb_q    <= opb_d;
      salida_q <= salida_d;
      hi_q     <= hi_d;
      zf_q     <= zf_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign Salida  = salida_q;
  assign Hi      = hi_q;
  assign ZF      = zf_q;
  assign DivZero = dz_q;

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d, ovf_calc;

  always_comb begin
    ovf_calc = 1'b0;
    if (ALU_Control == OpAdd) begin
      ovf_calc = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
    end else if (ALU_Control == OpSub) begin
      ovf_calc = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff[WIDTH-1] != OP1[WIDTH-1]);
    end
    ovf_d = ovf_q;
    // A done from IDLE is a single-cycle op; one from FIN is MUL/DIV, which never overflows.
    if (done_d) ovf_d = (state_q == StIdle) ? ovf_calc : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`endif

endmodule
